// File: rtl/adc_capture_control_if.sv
// rtl/adc_capture_control_if.sv - trigger, ADC sample, capture RAM and ARM interrupt signal bundle
//
// Ports (grouped signals):
//   iTrigLine / oTrigAck         trigger level from tx controller and its one-cycle ack
//   iAdcData / iAdcValid         ADC sample word and its qualifier
//   oRamWrEn/oRamWrAddr/oRamWrData  capture RAM write port
//   oArmInterrupt                interrupt request to ARM
//   iArmInterruptComms           bit7 = armAwake, bit0 = releasedByArm
// Modports: slave = capture engine view, master = driving environment view.
interface adc_capture_control_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
) ();
  logic              iTrigLine;
  logic              oTrigAck;
  logic [DATA_W-1:0] iAdcData;
  logic              iAdcValid;
  logic              oRamWrEn;
  logic [ADDR_W-1:0] oRamWrAddr;
  logic [DATA_W-1:0] oRamWrData;
  logic              oArmInterrupt;
  logic [7:0]        iArmInterruptComms;

  modport slave (
    input  iTrigLine, iAdcData, iAdcValid, iArmInterruptComms,
    output oTrigAck, oRamWrEn, oRamWrAddr, oRamWrData, oArmInterrupt
  );

  modport master (
    output iTrigLine, iAdcData, iAdcValid, iArmInterruptComms,
    input  oTrigAck, oRamWrEn, oRamWrAddr, oRamWrData, oArmInterrupt
  );
endinterface

// File: rtl/adc_capture_control.sv
// rtl/adc_capture_control.sv - triggered ADC capture engine with ARM handshake
//
// Ports:
//   adcCLK        sole clock
//   rcvRST        asynchronous active-high reset
//   bus           trigger / sample / RAM write / interrupt bundle (slave side)
//   iRecEnable    1 = armed, 0 = abort to IDLE
//   iRecLength    samples per capture, latched at trigger
//   iRecDelay     cycles from trigger acceptance to first sample, latched at trigger
//   iTimeout      cycle limit for the ARM handshake
//   oSampleCount  samples written in current/last capture
//   oTrigMissed   sticky: trigger seen while not ARMED
//   oState        current state encoding
module adc_capture_control #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
) (
  input  logic                adcCLK,
  input  logic                rcvRST,
  adc_capture_control_if.slave bus,
  input  logic                iRecEnable,
  input  logic [ADDR_W-1:0]   iRecLength,
  input  logic [15:0]         iRecDelay,
  input  logic [31:0]         iTimeout,
  output logic [ADDR_W-1:0]   oSampleCount,
  output logic                oTrigMissed,
  output logic [2:0]          oState
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    ARMED        = 3'd1,
    DELAY        = 3'd2,
    CAPTURE      = 3'd3,
    NOTIFY       = 3'd4,
    WAIT_RELEASE = 3'd5,
    ERROR        = 3'd6
  } stateT;

  stateT             state, stateNext;
  logic              trigPrev;
  logic              trigEvent;
  logic              trigAck;
  logic [ADDR_W-1:0] recLen;
  logic [15:0]       delayCnt;
  logic [31:0]       timer;
  logic              wrEn;
  logic [ADDR_W-1:0] wrAddr;
  logic [DATA_W-1:0] wrData;
  logic              acceptTrig;
  logic              doWrite;
  logic              timeoutHit;
  logic [ADDR_W-1:0] countPlusOne;
  logic              armAwake;
  logic              releasedByArm;
  logic              unusedCommsBits;

  assign armAwake        = bus.iArmInterruptComms[7];
  assign releasedByArm   = bus.iArmInterruptComms[0];
  assign unusedCommsBits = ^bus.iArmInterruptComms[6:1];

  // Rising edge of the level trigger; a held-high line produces one event only.
  assign trigEvent    = bus.iTrigLine & ~trigPrev;
  assign countPlusOne = oSampleCount + ADDR_W'(1);
  // Counting the cycle about to elapse lets ERROR land exactly iTimeout cycles after NOTIFY entry.
  assign timeoutHit   = (timer + 32'd1) >= iTimeout;

  always_ff @(posedge adcCLK or posedge rcvRST) begin
    if (rcvRST) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    acceptTrig = 1'b0;
    doWrite    = 1'b0;
    if (!iRecEnable) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE:    stateNext = ARMED;
        ARMED: begin
          if (trigEvent) begin
            acceptTrig = 1'b1;
            if (iRecLength == '0)     stateNext = NOTIFY;
            else if (iRecDelay == '0) stateNext = CAPTURE;
            else                      stateNext = DELAY;
          end
        end
        DELAY:   if (delayCnt <= 16'd1) stateNext = CAPTURE;
        CAPTURE: begin
          if (bus.iAdcValid) begin
            doWrite = 1'b1;
            if (countPlusOne == recLen) stateNext = NOTIFY;
          end
        end
        // A timeout outranks a handshake arriving on the same cycle.
        NOTIFY: begin
          if (timeoutHit)    stateNext = ERROR;
          else if (armAwake) stateNext = WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (timeoutHit)         stateNext = ERROR;
          else if (releasedByArm) stateNext = ARMED;
        end
        ERROR:   stateNext = ERROR;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge adcCLK or posedge rcvRST) begin
    if (rcvRST) begin
      trigPrev     <= 1'b0;
      trigAck      <= 1'b0;
      recLen       <= '0;
      delayCnt     <= '0;
      timer        <= '0;
      wrEn         <= 1'b0;
      wrAddr       <= '0;
      wrData       <= '0;
      oSampleCount <= '0;
      oTrigMissed  <= 1'b0;
    end else begin
      trigPrev <= bus.iTrigLine;
      trigAck  <= trigEvent;
      wrEn     <= 1'b0;

      // Setting wins over the arm-time clear so a trigger on that edge is not lost.
      if (trigEvent && state != ARMED)                 oTrigMissed <= 1'b1;
      else if (state == IDLE && stateNext == ARMED)    oTrigMissed <= 1'b0;

      if (acceptTrig) begin
        recLen       <= iRecLength;
        delayCnt     <= iRecDelay;
        oSampleCount <= '0;
      end else if (state == DELAY) begin
        delayCnt <= delayCnt - 16'd1;
      end

      if (doWrite) begin
        wrEn         <= 1'b1;
        wrAddr       <= oSampleCount;
        wrData       <= bus.iAdcData;
        oSampleCount <= countPlusOne;
      end

      if (state != NOTIFY && stateNext == NOTIFY)
        timer <= '0;
      else if (state == NOTIFY || state == WAIT_RELEASE)
        timer <= timer + 32'd1;
    end
  end

  assign bus.oTrigAck      = trigAck;
  assign bus.oRamWrEn      = wrEn;
  assign bus.oRamWrAddr    = wrAddr;
  assign bus.oRamWrData    = wrData;
  // Dropping enable silences the interrupt at once rather than a cycle later.
  assign bus.oArmInterrupt = (state == NOTIFY) && iRecEnable;
  assign oState            = state;

endmodule

// File: tb/tb_adc_capture_control.sv
// tb/tb_adc_capture_control.sv - scoreboard bench for adc_capture_control
module tb_adc_capture_control;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 32;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wrItemT;

  logic              adcCLK = 1'b0;
  logic              rcvRST;
  logic              iRecEnable;
  logic [ADDR_W-1:0] iRecLength;
  logic [15:0]       iRecDelay;
  logic [31:0]       iTimeout;
  logic [ADDR_W-1:0] oSampleCount;
  logic              oTrigMissed;
  logic [2:0]        oState;

  int nChecks = 0;
  int nFail   = 0;
  int cyc     = 0;

  wrItemT wrQ[$];
  int     ackQ[$];

  adc_capture_control_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  adc_capture_control #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .adcCLK       (adcCLK),
    .rcvRST       (rcvRST),
    .bus          (bus),
    .iRecEnable   (iRecEnable),
    .iRecLength   (iRecLength),
    .iRecDelay    (iRecDelay),
    .iTimeout     (iTimeout),
    .oSampleCount (oSampleCount),
    .oTrigMissed  (oTrigMissed),
    .oState       (oState)
  );

  always #5 adcCLK = ~adcCLK;
  always @(posedge adcCLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge adcCLK);
    #1;
  endtask

  task automatic handshake();
    bus.iArmInterruptComms = 8'h80;
    tick();
    bus.iArmInterruptComms = 8'h00;
    repeat (3) tick();
    bus.iArmInterruptComms = 8'h01;
    tick();
    bus.iArmInterruptComms = 8'h00;
  endtask

  // Monitor: every write and every ack the DUT presents must match the head of its queue.
  always @(negedge adcCLK) begin
    if (!rcvRST && bus.oRamWrEn) begin
      if (wrQ.size() == 0) begin
        check("unexpected_write", 32'(bus.oRamWrAddr), 32'hFFFF_FFFF);
      end else begin
        wrItemT e;
        e = wrQ.pop_front();
        check("wr_addr", 32'(bus.oRamWrAddr), 32'(e.addr));
        check("wr_data", bus.oRamWrData, e.data);
      end
    end
    if (!rcvRST && bus.oTrigAck) begin
      if (ackQ.size() == 0) begin
        check("unexpected_ack", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        check("ack_cycle", 32'(cyc), 32'(ackQ.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rcvRST                 = 1'b1;
    iRecEnable             = 1'b0;
    iRecLength             = '0;
    iRecDelay              = '0;
    iTimeout               = 32'd100;
    bus.iTrigLine          = 1'b0;
    bus.iAdcData           = '0;
    bus.iAdcValid          = 1'b0;
    bus.iArmInterruptComms = 8'h00;
    repeat (2) tick();
    check("rst_state", 32'(oState), 32'd0);
    check("rst_wren", 32'(bus.oRamWrEn), 32'd0);
    check("rst_ack", 32'(bus.oTrigAck), 32'd0);
    check("rst_irq", 32'(bus.oArmInterrupt), 32'd0);
    check("rst_count", 32'(oSampleCount), 32'd0);
    check("rst_missed", 32'(oTrigMissed), 32'd0);

    rcvRST     = 1'b0;
    iRecEnable = 1'b1;
    tick();
    check("armed", 32'(oState), 32'd1);

    // length 4, delay 0, trigger held 10 cycles, valid every cycle
    iRecLength = 15'd4;
    iRecDelay  = 16'd0;
    for (int k = 0; k < 4; k++) wrQ.push_back('{addr: ADDR_W'(k), data: 32'hA000_0001 + k});
    ackQ.push_back(cyc + 1);
    bus.iTrigLine = 1'b1;
    bus.iAdcValid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.iAdcData = 32'hA000_0000 + i;
      tick();
    end
    bus.iTrigLine = 1'b0;
    bus.iAdcValid = 1'b0;
    check("t1_state", 32'(oState), 32'd4);
    check("t1_count", 32'(oSampleCount), 32'd4);
    check("t1_irq", 32'(bus.oArmInterrupt), 32'd1);
    check("t1_missed", 32'(oTrigMissed), 32'd0);
    bus.iArmInterruptComms = 8'h80;
    tick();
    bus.iArmInterruptComms = 8'h00;
    check("t1_wait_release", 32'(oState), 32'd5);
    check("t1_irq_drop", 32'(bus.oArmInterrupt), 32'd0);
    repeat (3) tick();
    bus.iArmInterruptComms = 8'h01;
    tick();
    bus.iArmInterruptComms = 8'h00;
    check("t1_rearmed", 32'(oState), 32'd1);

    // delay 3: samples presented during DELAY must not be written
    iRecLength = 15'd2;
    iRecDelay  = 16'd3;
    wrQ.push_back('{addr: ADDR_W'(0), data: 32'hB000_0004});
    wrQ.push_back('{addr: ADDR_W'(1), data: 32'hB000_0005});
    ackQ.push_back(cyc + 1);
    bus.iTrigLine = 1'b1;
    bus.iAdcValid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.iAdcData = 32'hB000_0000 + i;
      tick();
      bus.iTrigLine = 1'b0;
      if (i == 0) check("t2_delay_entry", 32'(oState), 32'd2);
      if (i == 2) check("t2_delay_last", 32'(oState), 32'd2);
      if (i == 3) check("t2_capture", 32'(oState), 32'd3);
    end
    bus.iAdcValid = 1'b0;
    check("t2_state", 32'(oState), 32'd4);
    check("t2_count", 32'(oSampleCount), 32'd2);
    handshake();
    check("t2_rearmed", 32'(oState), 32'd1);

    // second trigger during CAPTURE, then handshake timeout of 20
    iTimeout   = 32'd20;
    iRecLength = 15'd6;
    iRecDelay  = 16'd0;
    for (int k = 0; k < 6; k++) wrQ.push_back('{addr: ADDR_W'(k), data: 32'hC000_0001 + k});
    bus.iAdcValid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.iTrigLine = (i == 0 || i == 2);
      if (i == 0 || i == 2) ackQ.push_back(cyc + 1);
      bus.iAdcData = 32'hC000_0000 + i;
      tick();
    end
    bus.iTrigLine = 1'b0;
    bus.iAdcValid = 1'b0;
    check("t3_missed", 32'(oTrigMissed), 32'd1);
    check("t3_state", 32'(oState), 32'd4);
    check("t3_count", 32'(oSampleCount), 32'd6);
    repeat (19) tick();
    check("t3_pre_timeout", 32'(oState), 32'd4);
    tick();
    check("t3_error", 32'(oState), 32'd6);
    check("t3_error_irq", 32'(bus.oArmInterrupt), 32'd0);
    repeat (3) tick();
    check("t3_error_sticky", 32'(oState), 32'd6);
    iRecEnable = 1'b0;
    tick();
    check("t3_idle", 32'(oState), 32'd0);
    check("t3_missed_kept", 32'(oTrigMissed), 32'd1);
    check("t3_count_kept", 32'(oSampleCount), 32'd6);
    iRecEnable = 1'b1;
    tick();
    check("t3_rearmed", 32'(oState), 32'd1);
    check("t3_missed_clear", 32'(oTrigMissed), 32'd0);

    // reset between edges mid-capture
    iTimeout   = 32'd100;
    iRecLength = 15'd8;
    for (int k = 0; k < 3; k++) wrQ.push_back('{addr: ADDR_W'(k), data: 32'hD000_0001 + k});
    ackQ.push_back(cyc + 1);
    bus.iTrigLine = 1'b1;
    bus.iAdcValid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.iAdcData = 32'hD000_0000 + i;
      tick();
    end
    @(negedge adcCLK);
    #2;
    rcvRST = 1'b1;
    #1;
    check("t4_rst_state", 32'(oState), 32'd0);
    check("t4_rst_wren", 32'(bus.oRamWrEn), 32'd0);
    check("t4_rst_count", 32'(oSampleCount), 32'd0);
    check("t4_rst_irq", 32'(bus.oArmInterrupt), 32'd0);
    repeat (3) tick();
    bus.iTrigLine = 1'b0;
    rcvRST        = 1'b0;
    repeat (4) tick();
    bus.iAdcValid = 1'b0;
    check("t4_after_rst", 32'(oState), 32'd1);
    check("t4_no_writes", 32'(bus.oRamWrEn), 32'd0);

    repeat (2) tick();
    check("wr_queue_empty", 32'(wrQ.size()), 32'd0);
    check("ack_queue_empty", 32'(ackQ.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
